kf_rom_loader: RTL and testbench

KF_ROM_LOADER -- requirements
Module: kf_rom_loader

---
 rtl/kf_rom_loader_pkg.sv | 20 ++
 rtl/kf_rom_loader.sv | 156 +++++++++++++++
 tb/tb_kf_rom_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_rom_loader_pkg.sv
// Shared definitions for the sequencer ROM loader: state encoding, default
// widths and the checksum seed.
package kf_rom_loader_pkg;

    localparam int DEF_IW     = 16;
    localparam int DEF_ROM_AW = 8;

    // The running XOR starts from this value at every new load.
    localparam logic [63:0] CSUM_SEED = 64'h0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } kf_state_t;

endpackage

// File: rtl/kf_rom_loader.sv
// Streams a length-prefixed, XOR-checksummed program into the sequencer ROM.
// One stream word per cycle; ROM writes are registered one cycle behind acceptance.
module kf_rom_loader
    import kf_rom_loader_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int ROM_AW = DEF_ROM_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [IW-1:0]     in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_waddr,
    output logic [IW-1:0]     rom_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ROM_AW:0] ROM_WORDS = {1'b1, {ROM_AW{1'b0}}};
    localparam logic [ROM_AW:0] CNT_ONE   = {{ROM_AW{1'b0}}, 1'b1};

    kf_state_t         state, state_nx;
    logic [ROM_AW:0]   cnt, cnt_nx, cnt_inc;
    logic [ROM_AW:0]   len, len_nx;
    logic [IW-1:0]     csum, csum_nx;
    logic              done_nx, err_nx;
    logic              accept;

    logic              wr_vld_p1, wr_vld_nx;
    logic [ROM_AW-1:0] wr_addr_p1, wr_addr_nx;
    logic [IW-1:0]     wr_data_p1, wr_data_nx;

    // Length occupies ROM_AW+1 bits so that a completely full ROM is expressible.
    function automatic logic hdr_len_bad(input logic [ROM_AW:0] n);
        return (n == '0) || (n > ROM_WORDS);
    endfunction

    assign in_ready = (state == HDR) || (state == DATA) || (state == CSUM);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_ONE;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        len_nx     = len;
        csum_nx    = csum;
        done_nx    = load_done;
        err_nx     = load_err;
        wr_vld_nx  = 1'b0;
        wr_addr_nx = wr_addr_p1;
        wr_data_nx = wr_data_p1;

        case (state)
            IDLE, DONE, ERR: begin
                if (load_req && !abort) begin
                    state_nx = HDR;
                    cnt_nx   = '0;
                    csum_nx  = IW'(CSUM_SEED);
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            HDR: begin
                if (abort) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end else if (accept) begin
                    if (hdr_len_bad(in_data[ROM_AW:0])) begin
                        state_nx = ERR;
                        err_nx   = 1'b1;
                    end else begin
                        len_nx   = in_data[ROM_AW:0];
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end else if (accept) begin
                    // cnt < len <= 2^ROM_AW here, so the low bits are the address.
                    wr_vld_nx  = 1'b1;
                    wr_addr_nx = cnt[ROM_AW-1:0];
                    wr_data_nx = in_data;
                    csum_nx    = csum ^ in_data;
                    cnt_nx     = cnt_inc;
                    if (cnt_inc == len) begin
                        state_nx = CSUM;
                    end
                end
            end
            CSUM: begin
                if (abort) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end else if (accept) begin
                    if (in_data == csum) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ERR;
                        err_nx   = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            csum      <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            len       <= len_nx;
            csum      <= csum_nx;
            load_done <= done_nx;
            load_err  <= err_nx;
        end
    end

    // ROM write stage: one cycle after acceptance; reset drops any pending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1  <= wr_vld_nx;
            wr_addr_p1 <= wr_addr_nx;
            wr_data_p1 <= wr_data_nx;
        end
    end

    assign rom_we    = wr_vld_p1;
    assign rom_waddr = wr_addr_p1;
    assign rom_wdata = wr_data_p1;

    // Busy also covers a final write still in flight after an abort.
    assign load_busy = in_ready || wr_vld_p1;

endmodule

// File: tb/tb_kf_rom_loader.sv
// Directed bench for kf_rom_loader with a write scoreboard fed by the stimulus.
module tb_kf_rom_loader;

    localparam int IW     = 16;
    localparam int ROM_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [IW-1:0]     in_data = '0;
    logic              in_ready;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_waddr;
    logic [IW-1:0]     rom_wdata;
    logic              load_busy;
    logic              load_done;
    logic              load_err;

    kf_rom_loader #(.IW(IW), .ROM_AW(ROM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_req  (load_req),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROM_AW-1:0] addr;
        logic [IW-1:0]     data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_w;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_wr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every observed ROM write must match the next expected one.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         rom_waddr, rom_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (rom_waddr !== exp_w.addr || rom_wdata !== exp_w.data) begin
                    n_bad++;
                    $display("FAIL rom_write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             rom_waddr, rom_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                step();
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed low, word 0x%0h not taken", w);
        end
    endtask

    task automatic send_data(input int addr, input logic [IW-1:0] w);
        exp_q.push_back({addr[ROM_AW-1:0], w});
        send_word(w);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic good_load();
        pulse_req();
        chk("start_err_cleared", {31'b0, load_err}, 32'd0);
        chk("start_done_cleared", {31'b0, load_done}, 32'd0);
        send_word(16'd3);
        send_data(0, 16'h1234);
        send_data(1, 16'h00F0);
        send_data(2, 16'hA001);
        send_word(16'hB2C5);
    endtask

    logic [IW-1:0] w, ref_csum;
    int            wr_base;

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
        chk("rst_rom_we",    {31'b0, rom_we},    32'd0);
        chk("rst_rom_waddr", {24'b0, rom_waddr}, 32'd0);
        chk("rst_rom_wdata", {16'b0, rom_wdata}, 32'd0);
        chk("rst_busy",      {31'b0, load_busy}, 32'd0);
        chk("rst_done",      {31'b0, load_done}, 32'd0);
        chk("rst_err",       {31'b0, load_err},  32'd0);
        #5 rst_n = 1'b1;
        step();

        // Good load, with a load_req mid-load that must be ignored
        pulse_req();
        chk("hdr_busy",  {31'b0, load_busy}, 32'd1);
        chk("hdr_ready", {31'b0, in_ready},  32'd1);
        send_word(16'd3);
        send_data(0, 16'h1234);
        pulse_req();
        send_data(1, 16'h00F0);
        send_data(2, 16'hA001);
        send_word(16'hB2C5);
        chk("good_done",  {31'b0, load_done}, 32'd1);
        chk("good_err",   {31'b0, load_err},  32'd0);
        chk("good_busy",  {31'b0, load_busy}, 32'd0);
        chk("good_ready", {31'b0, in_ready},  32'd0);

        // abort outside a load does nothing
        pulse_abort();
        chk("idle_abort_done", {31'b0, load_done}, 32'd1);
        chk("idle_abort_err",  {31'b0, load_err},  32'd0);

        // Bad checksum
        pulse_req();
        chk("badcs_done_cleared", {31'b0, load_done}, 32'd0);
        send_word(16'd3);
        send_data(0, 16'h1234);
        send_data(1, 16'h00F0);
        send_data(2, 16'hA001);
        send_word(16'h0000);
        chk("badcs_err",  {31'b0, load_err},  32'd1);
        chk("badcs_done", {31'b0, load_done}, 32'd0);

        // Bad headers: zero length and one past the ROM size
        pulse_req();
        chk("hdr0_err_cleared", {31'b0, load_err}, 32'd0);
        send_word(16'd0);
        chk("hdr0_err",   {31'b0, load_err}, 32'd1);
        chk("hdr0_ready", {31'b0, in_ready}, 32'd0);
        pulse_req();
        send_word(16'd257);
        chk("hdr257_err",  {31'b0, load_err},  32'd1);
        chk("hdr257_done", {31'b0, load_done}, 32'd0);

        // Header upper bits ignored: 0xFE03 means length 3
        pulse_req();
        send_word(16'hFE03);
        send_data(0, 16'hFFFF);
        send_data(1, 16'h0001);
        send_data(2, 16'h8000);
        send_word(16'h7FFE);
        chk("hdrhi_done", {31'b0, load_done}, 32'd1);

        // Full ROM with random gaps
        pulse_req();
        send_word(16'h0100);
        wr_base  = n_wr;
        ref_csum = '0;
        for (int i = 0; i < 256; i++) begin
            w = 16'(i * 16'h0107) ^ 16'hC3A5;
            ref_csum = ref_csum ^ w;
            send_data(i, w);
            repeat ($urandom_range(0, 2)) step();
        end
        send_word(ref_csum);
        chk("full_ready_after_csum", {31'b0, in_ready}, 32'd0);
        chk("full_done", {31'b0, load_done}, 32'd1);
        step();
        chk("full_write_count", n_wr - wr_base, 32'd256);

        // abort after two data words, then a clean reload
        pulse_req();
        send_word(16'd5);
        send_data(0, 16'h1111);
        send_data(1, 16'h2222);
        pulse_abort();
        chk("abort_err",   {31'b0, load_err},  32'd1);
        chk("abort_done",  {31'b0, load_done}, 32'd0);
        chk("abort_ready", {31'b0, in_ready},  32'd0);
        step();
        chk("abort_busy",  {31'b0, load_busy}, 32'd0);
        good_load();
        chk("reload_done", {31'b0, load_done}, 32'd1);
        chk("reload_err",  {31'b0, load_err},  32'd0);

        // Reset mid-DATA: the second word's write is cut off by reset
        pulse_req();
        send_word(16'd4);
        send_data(0, 16'h5555);
        send_word(16'h6666);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_we", {31'b0, rom_we},    32'd0);
        chk("mid_rst_waddr",  {24'b0, rom_waddr}, 32'd0);
        chk("mid_rst_wdata",  {16'b0, rom_wdata}, 32'd0);
        chk("mid_rst_busy",   {31'b0, load_busy}, 32'd0);
        chk("mid_rst_ready",  {31'b0, in_ready},  32'd0);
        chk("mid_rst_done",   {31'b0, load_done}, 32'd0);
        chk("mid_rst_err",    {31'b0, load_err},  32'd0);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        chk("post_rst_ready", {31'b0, in_ready},  32'd0);
        chk("post_rst_busy",  {31'b0, load_busy}, 32'd0);

        repeat (3) step();
        chk("pending_writes", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
